// File: rtl/sdram_wr_burst.sv
// Burst writer: moves BURST_LEN words from a show-ahead FIFO to an SDRAM controller per request.
// Define SDRAM_WR_ADDR_WRAP_EN to wrap the address to ADDR_BASE past ADDR_LIMIT instead of halting.
module sdram_wr_burst #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CNT_WIDTH  = 10,
  parameter int unsigned BURST_LEN  = 8,
  parameter int unsigned ADDR_WIDTH = 24,
  parameter int unsigned ADDR_BASE  = 0,
  parameter int unsigned ADDR_LIMIT = (32'd1 << ADDR_WIDTH) - BURST_LEN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [CNT_WIDTH-1:0]  fifo_rd_cnt,
  input  logic                  fifo_rd_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_req,
  output logic                  wr_req,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic                  wr_ack,
  input  logic                  wr_data_en,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  burst_done,
  output logic                  underflow,
  output logic                  addr_ovf
);

  localparam int unsigned BEAT_W = $clog2(BURST_LEN + 1);
  localparam int unsigned SUM_W  = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {IDLE, REQ, DATA, DONE, STOP} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [BEAT_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic                   wr_req_q, wr_req_d;
  logic                   burst_done_q, burst_done_d;
  logic                   underflow_q, underflow_d;
  logic                   addr_ovf_q, addr_ovf_d;

  logic [SUM_W-1:0]       addr_sum;
  logic [ADDR_WIDTH-1:0]  addr_next;
  logic                   addr_over;
  logic                   burst_ready;
  logic                   beat_open;

  // One extra bit keeps the carry so a start address at the very top still counts as past the limit.
  assign addr_sum    = {1'b0, addr_q} + SUM_W'(BURST_LEN);
  assign addr_over   = addr_sum > SUM_W'(ADDR_LIMIT);
  assign burst_ready = enable && (32'(fifo_rd_cnt) >= BURST_LEN);
  assign beat_open   = beat_cnt_q < BEAT_W'(BURST_LEN);

`ifdef SDRAM_WR_ADDR_WRAP_EN
  assign addr_next = addr_over ? ADDR_WIDTH'(ADDR_BASE) : addr_sum[ADDR_WIDTH-1:0];
`else
  assign addr_next = addr_sum[ADDR_WIDTH-1:0];
`endif

  // Next-state, datapath and combinational FIFO/data outputs.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    beat_cnt_d  = beat_cnt_q;
    underflow_d = underflow_q;
`ifdef SDRAM_WR_ADDR_WRAP_EN
    addr_ovf_d  = 1'b0;
`else
    addr_ovf_d  = addr_ovf_q;
`endif
    fifo_rd_req = 1'b0;
    wr_data     = '0;

    case (state_q)
      IDLE: begin
        if (burst_ready) state_d = REQ;
      end
      REQ: begin
        if (wr_ack) begin
          state_d    = DATA;
          beat_cnt_d = '0;
        end
      end
      DATA: begin
        wr_data     = fifo_rd_data;
        fifo_rd_req = wr_data_en && !fifo_rd_empty && beat_open;
        if (wr_data_en && beat_open) begin
          beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          if (fifo_rd_empty) underflow_d = 1'b1;
          // Overflow is flagged on entry so addr_ovf is already high during DONE.
          if (beat_cnt_q == BEAT_W'(BURST_LEN - 1)) begin
            state_d = DONE;
            if (addr_over) addr_ovf_d = 1'b1;
          end
        end
      end
      DONE: begin
        addr_d = addr_next;
`ifdef SDRAM_WR_ADDR_WRAP_EN
        state_d = IDLE;
`else
        state_d = addr_over ? STOP : IDLE;
`endif
      end
      STOP: begin
        state_d = STOP;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    wr_req_d     = (state_d == REQ);
    burst_done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= ADDR_WIDTH'(ADDR_BASE);
      beat_cnt_q   <= '0;
      wr_req_q     <= 1'b0;
      burst_done_q <= 1'b0;
      underflow_q  <= 1'b0;
      addr_ovf_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      beat_cnt_q   <= beat_cnt_d;
      wr_req_q     <= wr_req_d;
      burst_done_q <= burst_done_d;
      underflow_q  <= underflow_d;
      addr_ovf_q   <= addr_ovf_d;
    end
  end

  assign wr_req     = wr_req_q;
  assign wr_addr    = addr_q;
  assign burst_done = burst_done_q;
  assign underflow  = underflow_q;
  assign addr_ovf   = addr_ovf_q;

endmodule

// File: tb/tb_sdram_wr_burst.sv
// Bench for sdram_wr_burst: burst-level reference model checked every cycle plus directed scenarios.
module tb_sdram_wr_burst;

  localparam int DW    = 16;
  localparam int CW    = 10;
  localparam int BL    = 8;
  localparam int AW    = 24;
  localparam int ABASE = 0;
  localparam int ALIM  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [CW-1:0] fifo_rd_cnt;
  logic          fifo_rd_empty;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_rd_req;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic          wr_ack = 1'b0;
  logic          wr_data_en = 1'b0;
  logic [DW-1:0] wr_data;
  logic          burst_done;
  logic          underflow;
  logic          addr_ovf;

  sdram_wr_burst #(
    .DATA_WIDTH(DW), .CNT_WIDTH(CW), .BURST_LEN(BL), .ADDR_WIDTH(AW),
    .ADDR_BASE(ABASE), .ADDR_LIMIT(ALIM)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .fifo_rd_cnt(fifo_rd_cnt), .fifo_rd_empty(fifo_rd_empty), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_req(fifo_rd_req), .wr_req(wr_req), .wr_addr(wr_addr), .wr_ack(wr_ack),
    .wr_data_en(wr_data_en), .wr_data(wr_data), .burst_done(burst_done),
    .underflow(underflow), .addr_ovf(addr_ovf)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Upstream show-ahead FIFO
  logic [DW-1:0] fq[$];
  bit force_empty = 1'b0;
  bit pop_pending = 1'b0;

  task automatic drive_fifo();
    fifo_rd_cnt   = CW'(fq.size());
    fifo_rd_empty = (fq.size() == 0) || force_empty;
    fifo_rd_data  = (fq.size() != 0) ? fq[0] : '0;
  endtask

  task automatic push_words(input int first, input int n);
    for (int i = 0; i < n; i++) fq.push_back(DW'(first + i));
    drive_fifo();
  endtask

  // Burst-level reference model
  bit            m_req, m_acked, m_fin, m_halt, m_under;
  int            m_beats;
  logic [AW-1:0] m_addr;

  task automatic m_reset();
    m_req = 0; m_acked = 0; m_fin = 0; m_halt = 0; m_under = 0;
    m_beats = 0; m_addr = AW'(ABASE);
  endtask

  task automatic model_step();
    int sum;
    if (!rst_n) begin
      m_reset();
      return;
    end
    if (m_halt) begin
    end else if (m_fin) begin
      sum = int'(m_addr) + BL;
      m_fin = 0;
      if (sum > ALIM) begin
`ifdef SDRAM_WR_ADDR_WRAP_EN
        m_addr = AW'(ABASE);
`else
        m_addr = AW'(sum);
        m_halt = 1;
`endif
      end else begin
        m_addr = AW'(sum);
      end
    end else if (m_acked) begin
      if (wr_data_en) begin
        m_beats++;
        if (fifo_rd_empty) m_under = 1;
        if (m_beats == BL) begin
          m_acked = 0;
          m_fin   = 1;
        end
      end
    end else if (m_req) begin
      if (wr_ack) begin
        m_req = 0; m_acked = 1; m_beats = 0;
      end
    end else if (enable && int'(fifo_rd_cnt) >= BL) begin
      m_req = 1;
    end
  endtask

  always @(negedge rst_n) m_reset();

  always @(posedge clk) begin
    model_step();
    #1;
    if (pop_pending && fq.size() > 0) void'(fq.pop_front());
    drive_fifo();
  end

  // Monitor logs
  logic [AW-1:0] addr_log[$];
  logic [DW-1:0] data_log[$];
  int pops = 0, dones = 0, ovf_rises = 0, cyc = 0, last_pop_cyc = 0, done_cyc = 0;
  bit req_prev = 0, ovf_prev = 0;

  always @(negedge clk) begin
    bit over;
    pop_pending = fifo_rd_req;
    if (chk_on) begin
      over = (int'(m_addr) + BL) > ALIM;
      chk("wr_req", wr_req, m_req);
      chk("wr_addr", wr_addr, m_addr);
      chk("fifo_rd_req", fifo_rd_req, m_acked && wr_data_en && !fifo_rd_empty && (m_beats < BL));
      chk("wr_data", wr_data, m_acked ? fifo_rd_data : 16'h0);
      chk("burst_done", burst_done, m_fin);
      chk("underflow", underflow, m_under);
`ifdef SDRAM_WR_ADDR_WRAP_EN
      chk("addr_ovf", addr_ovf, m_fin && over);
`else
      chk("addr_ovf", addr_ovf, m_halt || (m_fin && over));
`endif
    end
    cyc++;
    if (wr_req && !req_prev) addr_log.push_back(wr_addr);
    req_prev = wr_req;
    if (fifo_rd_req) begin
      data_log.push_back(wr_data);
      pops++;
      last_pop_cyc = cyc;
    end
    if (burst_done) begin
      dones++;
      done_cyc = cyc;
    end
    if (addr_ovf && !ovf_prev) ovf_rises++;
    ovf_prev = addr_ovf;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_req(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (wr_req === 1'b1) begin
        ok = 1;
        break;
      end
      tick();
    end
    chk(name, ok, 1);
  endtask

  task automatic ack();
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
  endtask

  task automatic beats(input logic [31:0] pat, input int n);
    for (int i = 0; i < n; i++) begin
      wr_data_en = pat[i];
      tick();
    end
    wr_data_en = 1'b0;
  endtask

  initial begin
    int pbase, dbase;
    m_reset();
    drive_fifo();
    #12;
    chk("rst_wr_req", wr_req, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_burst_done", burst_done, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_addr_ovf", addr_ovf, 0);
    chk("rst_fifo_rd_req", fifo_rd_req, 0);
    chk("rst_wr_data", wr_data, 0);
    chk_on = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();

    // Basic burst: words 0..7 at address 0
    push_words(0, 8);
    enable = 1'b1;
    expect_req("req_burst1");
    ack();
    beats(32'hFF, 8);
    repeat (3) tick();
    chk("b1_addr_count", addr_log.size(), 1);
    chk("b1_addr", addr_log[0], 0);
    chk("b1_pops", pops, 8);
    for (int i = 0; i < 8; i++) chk("b1_data", data_log[i], i);
    chk("b1_dones", dones, 1);
    chk("b1_next_addr", wr_addr, 8);

    // Seven words must not start a burst; the eighth does; gapped data enables
    push_words(8, 7);
    repeat (5) tick();
    chk("cnt7_no_req", wr_req, 0);
    push_words(15, 1);
    expect_req("req_burst2");
    chk("b2_addr", wr_addr, 8);
    ack();
    beats(32'h0001_5555, 17);
    repeat (2) tick();
    chk("b2_pops", pops, 16);
    chk("b2_dones", dones, 2);
    chk("b2_done_latency", done_cyc - last_pop_cyc, 1);
    for (int i = 0; i < 8; i++) chk("b2_data", data_log[8 + i], 8 + i);

    // Address limit crossed by the second burst
    push_words(16, 8);
`ifdef SDRAM_WR_ADDR_WRAP_EN
    expect_req("req_burst3_wrap");
    chk("b3_addr_wrap", wr_addr, 0);
    ack();
    beats(32'hFF, 8);
    repeat (3) tick();
    chk("b3_pops", pops, 24);
    chk("ovf_pulse_count", ovf_rises, 1);
    chk("ovf_after_pulse", addr_ovf, 0);
`else
    chk("stop_ovf", addr_ovf, 1);
    repeat (20) tick();
    chk("stop_no_req", addr_log.size(), 2);
    chk("stop_no_pop", pops, 16);
    chk("stop_ovf_sticky", addr_ovf, 1);
    chk("ovf_rise_count", ovf_rises, 1);
`endif

    // Underflow on beat 5
    rst_n = 1'b0;
    tick();
    fq.delete();
    drive_fifo();
    rst_n = 1'b1;
    tick();
    pbase = pops;
    dbase = dones;
    push_words(32, 8);
    expect_req("req_burst_uf");
    chk("uf_addr", wr_addr, 0);
    ack();
    for (int i = 0; i < 8; i++) begin
      wr_data_en  = 1'b1;
      force_empty = (i == 4);
      drive_fifo();
      tick();
    end
    wr_data_en  = 1'b0;
    force_empty = 1'b0;
    drive_fifo();
    repeat (3) tick();
    chk("uf_pops", pops - pbase, 7);
    chk("uf_dones", dones - dbase, 1);
    chk("uf_sticky", underflow, 1);
    chk("uf_fifo_left", fq.size(), 1);
    chk("uf_last_word", data_log[data_log.size() - 1], 38);

    // Reset during DATA beat 3
    push_words(40, 7);
    expect_req("req_burst_rst");
    chk("rst_burst_addr", wr_addr, 8);
    ack();
    beats(32'h7, 3);
    wr_data_en = 1'b1;
    #1;
    chk("pre_rst_pop", fifo_rd_req, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_fifo_rd_req", fifo_rd_req, 0);
    chk("mid_rst_wr_data", wr_data, 0);
    chk("mid_rst_wr_req", wr_req, 0);
    chk("mid_rst_burst_done", burst_done, 0);
    chk("mid_rst_underflow", underflow, 0);
    chk("mid_rst_addr_ovf", addr_ovf, 0);
    chk("mid_rst_wr_addr", wr_addr, 0);
    tick();
    wr_data_en = 1'b0;
    rst_n = 1'b1;
    push_words(47, 8 - fq.size());
    expect_req("req_after_rst");
    chk("after_rst_addr", wr_addr, 0);
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule

// File: doc/sdram_wr_burst.md
SDRAM_WR_BURST -- requirements
Module: sdram_wr_burst

Interface
REQ-001 Parameters SHALL be:
- DATA_WIDTH, 16, word width.
- CNT_WIDTH, 10, width of the FIFO fill count.
- BURST_LEN, 8, words per burst (power of two, 1..256).
- ADDR_WIDTH, 24, SDRAM word address width.
- ADDR_BASE, 0, first burst address.
- ADDR_LIMIT, 2^24-BURST_LEN, last legal burst start address.
REQ-002 Ports SHALL be:
- clk  in  1  single clock.
- rst_n  in  1  reset: asynchronous, active-low.
- enable  in  1  permits new bursts.
- fifo_rd_cnt  in  CNT_WIDTH  words available in the upstream FIFO.
- fifo_rd_empty  in  1  upstream FIFO empty.
- fifo_rd_data  in  DATA_WIDTH  show-ahead FIFO head word.
- fifo_rd_req  out  1  pop FIFO head.
- wr_req  out  1  burst request to the SDRAM controller.
- wr_addr  out  ADDR_WIDTH  burst start address.
- wr_ack  in  1  controller accepts the burst.
- wr_data_en  in  1  controller takes one data word this cycle.
- wr_data  out  DATA_WIDTH  burst data.
- burst_done  out  1  one-cycle pulse per completed burst.
- underflow  out  1  sticky error flag.
- addr_ovf  out  1  address-limit indication.

Function
REQ-003 The FSM SHALL have the states IDLE, REQ, DATA, DONE and STOP.
REQ-004 IDLE SHALL go to REQ on the next edge when enable=1 and fifo_rd_cnt >= BURST_LEN; otherwise it SHALL stay in IDLE.
REQ-005 In REQ, wr_req SHALL be 1 (registered) and wr_addr SHALL hold the current address; on wr_ack=1 the FSM SHALL go to DATA and wr_req SHALL be 0 from the next cycle.
REQ-006 wr_ack SHALL be ignored outside REQ.
REQ-007 In DATA, fifo_rd_req SHALL equal wr_data_en AND NOT fifo_rd_empty AND (beat_cnt < BURST_LEN), combinationally.
REQ-008 wr_data SHALL equal fifo_rd_data combinationally in DATA and SHALL be 0 otherwise.
REQ-009 beat_cnt SHALL be 0 on entry to DATA and SHALL increment on every cycle with wr_data_en=1.
REQ-010 When beat_cnt reaches BURST_LEN, the FSM SHALL go to DATA→DONE; wr_data_en beyond BURST_LEN beats SHALL be ignored.
REQ-011 A cycle in DATA with wr_data_en=1 and fifo_rd_empty=1 SHALL set underflow=1 (sticky until reset); the beat SHALL still count, with no pop.
REQ-012 DONE SHALL last one cycle, pulse burst_done=1, and advance the address by BURST_LEN.
REQ-013 Address arithmetic SHALL be ADDR_WIDTH-bit unsigned.
REQ-014 If the advanced address exceeds ADDR_LIMIT, behaviour SHALL be as defined in Configuration; otherwise DONE SHALL go to IDLE.
REQ-015 Dropping enable SHALL only block IDLE→REQ; a burst already in REQ or DATA SHALL complete.
REQ-016 fifo_rd_req SHALL be 0 in every state other than DATA.

Reset
REQ-017 On rst_n=0, asynchronously:
- state SHALL be IDLE;
- address SHALL be ADDR_BASE;
- beat_cnt SHALL be 0;
- wr_req, burst_done, underflow and addr_ovf SHALL be 0.
REQ-018 Reset asserted mid-burst SHALL abandon the burst; after release the FSM SHALL restart from IDLE at ADDR_BASE.

Configuration
REQ-019 Macro SDRAM_WR_ADDR_WRAP_EN defined: on overflow the address SHALL wrap to ADDR_BASE, addr_ovf SHALL pulse for the DONE cycle only, and DONE SHALL go to IDLE.
REQ-020 Macro SDRAM_WR_ADDR_WRAP_EN undefined: on overflow the FSM SHALL enter STOP and addr_ovf SHALL be 1 and sticky; STOP SHALL issue no requests and no pops and SHALL be exited only by reset.

Verification
REQ-021 BURST_LEN=8, fifo_rd_cnt=8, enable=1, wr_ack one cycle after wr_req, wr_data_en high for 8 cycles -> wr_addr=0; data words 0..7 appear in order; 8 pops; burst_done pulses; next wr_addr=8.
REQ-022 fifo_rd_cnt=7, enable=1 -> wr_req stays 0 until fifo_rd_cnt=8.
REQ-023 wr_data_en gapped 1-0-1-0 for 16 cycles -> exactly 8 pops; burst_done 1 cycle after the 8th beat; a 9th wr_data_en is ignored.
REQ-024 fifo_rd_empty=1 on beat 5 -> underflow=1 persists; no pop that cycle; burst still ends after 8 beats.
REQ-025 ADDR_BASE=0, ADDR_LIMIT=8, two bursts -> with macro: third wr_addr=0 and addr_ovf pulses once; without macro: STOP, addr_ovf stays 1, no third wr_req.
REQ-026 rst_n low during DATA beat 3 -> all outputs 0 immediately; after release the next wr_addr is ADDR_BASE.
